// File: rtl/sevenseg_pkg.sv
// Shared symbol codes and segment constants for the seven-segment display blocks.
package sevenseg_pkg;

  typedef logic [4:0] sym_t;

  localparam sym_t       SYM_EQ    = 5'h10;
  localparam sym_t       SYM_MINUS = 5'h11;
  localparam sym_t       SYM_BLANK = 5'h12;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational symbol-to-glyph lookup; segments {g..a}, active low.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [4:0] sym_i,
  output logic [6:0] seg_o
);

  // Glyph table; unknown codes fall through to dark.
  always_comb begin
    seg_o = SEG_OFF;
    case (sym_i)
      5'h00:     seg_o = 7'h40;
      5'h01:     seg_o = 7'h79;
      5'h02:     seg_o = 7'h24;
      5'h03:     seg_o = 7'h30;
      5'h04:     seg_o = 7'h19;
      5'h05:     seg_o = 7'h12;
      5'h06:     seg_o = 7'h02;
      5'h07:     seg_o = 7'h78;
      5'h08:     seg_o = 7'h00;
      5'h09:     seg_o = 7'h10;
      5'h0A:     seg_o = 7'h08;
      5'h0B:     seg_o = 7'h03;
      5'h0C:     seg_o = 7'h46;
      5'h0D:     seg_o = 7'h21;
      5'h0E:     seg_o = 7'h06;
      5'h0F:     seg_o = 7'h0E;
      SYM_EQ:    seg_o = 7'h37;
      SYM_MINUS: seg_o = 7'h3F;
      default:   seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment scanner with double-buffered loading,
// blink, leading-zero suppression and PWM brightness.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 17,
  parameter int DUTY_BITS  = 3,
  parameter int BLINK_BITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] code,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  input  logic [DUTY_BITS-1:0]    brightness,
  output logic                    load_pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              A2G,
  output logic                    DP
);

  localparam int              IW       = $clog2(NUM_DIGITS);
  localparam int              CW       = 5 * NUM_DIGITS;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]   ALL_BLANK = {NUM_DIGITS{SYM_BLANK}};

  logic [DIV_BITS-1:0]   prescaler_q, prescaler_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BLINK_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                  frame_done_q, frame_done_d;

  logic [CW-1:0]         act_code_q, act_code_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d;
  logic [CW-1:0]         pend_code_q, pend_code_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d;
  logic                  load_pending_q, load_pending_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            a2g_q, a2g_d;
  logic                  dp_q, dp_d;

  logic                  tick_s;
  logic                  wrap_s;
  sym_t                  cur_sym_s;
  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] lz_blank_s;
  logic                  blank_s;
  logic                  lit_s;

  sevenseg_decode u_decode (
    .sym_i (cur_sym_s),
    .seg_o (seg_s)
  );

  // Scan timing: prescaler, digit index, frame counter and wrap pulse.
  always_comb begin
    prescaler_d  = prescaler_q + DIV_BITS'(1);
    tick_s       = &prescaler_q;
    wrap_s       = tick_s && (idx_q == LAST_IDX);
    frame_done_d = wrap_s;
    if (wrap_s) begin
      idx_d = '0;
    end else if (tick_s) begin
      idx_d = idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
    frame_cnt_d = wrap_s ? frame_cnt_q + BLINK_BITS'(1) : frame_cnt_q;
  end

  // Double buffer: active content only changes on the frame wrap.
  always_comb begin
    act_code_d     = act_code_q;
    act_dp_d       = act_dp_q;
    act_blink_d    = act_blink_q;
    pend_code_d    = load ? code       : pend_code_q;
    pend_dp_d      = load ? dp_in      : pend_dp_q;
    pend_blink_d   = load ? blink_mask : pend_blink_q;
    load_pending_d = load_pending_q;
    if (wrap_s && load) begin
      act_code_d     = code;
      act_dp_d       = dp_in;
      act_blink_d    = blink_mask;
      load_pending_d = 1'b0;
    end else if (wrap_s && load_pending_q) begin
      act_code_d     = pend_code_q;
      act_dp_d       = pend_dp_q;
      act_blink_d    = pend_blink_q;
      load_pending_d = 1'b0;
    end else if (load) begin
      load_pending_d = 1'b1;
    end else begin
      load_pending_d = load_pending_q;
    end
  end

  // Per-digit blanking, glyph select and PWM gating for the next output word.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lz_blank_s = '0;
    cur_sym_s  = SYM_BLANK;
    // Walk from the most significant digit down so zero_run means "this and all above are 0".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (act_code_q[5*i +: 5] == 5'h00);
      lz_blank_s[i] = lz_suppress && (i != 0) && zero_run;
      cur_sym_s     = (IW'(i) == idx_q) ? act_code_q[5*i +: 5] : cur_sym_s;
    end
    blank_s = (act_blink_q[idx_q] && frame_cnt_q[BLINK_BITS-1]) || lz_blank_s[idx_q];
    lit_s   = prescaler_q[DIV_BITS-1 -: DUTY_BITS] <= brightness;
    an_d    = {NUM_DIGITS{1'b1}};
    if (lit_s) begin
      an_d[idx_q] = 1'b0;
    end else begin
      an_d[idx_q] = 1'b1;
    end
    a2g_d = blank_s ? SEG_OFF : seg_s;
    dp_d  = blank_s ? 1'b1 : ~act_dp_q[idx_q];
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      frame_done_q   <= 1'b0;
      act_code_q     <= ALL_BLANK;
      act_dp_q       <= '0;
      act_blink_q    <= '0;
      pend_code_q    <= ALL_BLANK;
      pend_dp_q      <= '0;
      pend_blink_q   <= '0;
      load_pending_q <= 1'b0;
      an_q           <= {NUM_DIGITS{1'b1}};
      a2g_q          <= SEG_OFF;
      dp_q           <= 1'b1;
    end else begin
      prescaler_q    <= prescaler_d;
      idx_q          <= idx_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_done_q   <= frame_done_d;
      act_code_q     <= act_code_d;
      act_dp_q       <= act_dp_d;
      act_blink_q    <= act_blink_d;
      pend_code_q    <= pend_code_d;
      pend_dp_q      <= pend_dp_d;
      pend_blink_q   <= pend_blink_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      a2g_q          <= a2g_d;
      dp_q           <= dp_d;
    end
  end

  assign load_pending = load_pending_q;
  assign frame_done   = frame_done_q;
  assign AN           = an_q;
  assign A2G          = a2g_q;
  assign DP           = dp_q;

endmodule
